// File: rtl/pixel_unloader.sv
// Output stage of the filter pipeline: rebuilds a full IMG_WIDTH x IMG_HEIGHT raster
// from an interior-only pixel stream, re-inserting border padding behind a valid/ready port.
module pixel_unloader #(
  parameter int         IMG_WIDTH  = 512,
  parameter int         IMG_HEIGHT = 512,
  parameter int         BORDER     = 1,
  parameter int         FIFO_DEPTH = 16,
  parameter logic [7:0] PAD_VALUE  = 8'd0,
  localparam int        LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic [7:0]    pixel_in,
  input  logic          pixel_in_valid,
  output logic [7:0]    pixel_out,
  output logic          pixel_out_valid,
  input  logic          pixel_out_ready,
  output logic          pixel_out_sof,
  output logic          pixel_out_eol,
  output logic          pixel_out_eof,
  output logic          frame_done,
  output logic          overflow,
  output logic [LW-1:0] fifo_level
);

  localparam int AW = LW - 1;
  // Counter widths can represent IMG_WIDTH/IMG_HEIGHT themselves so the border bounds never wrap.
  localparam int CW = $clog2(IMG_WIDTH + 1);
  localparam int RW = $clog2(IMG_HEIGHT + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [CW-1:0] COL_LO   = CW'(BORDER);
  localparam logic [CW-1:0] COL_HI   = CW'(IMG_WIDTH - BORDER);
  localparam logic [CW-1:0] COL_ONE  = CW'(1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
  localparam logic [RW-1:0] ROW_LO   = RW'(BORDER);
  localparam logic [RW-1:0] ROW_HI   = RW'(IMG_HEIGHT - BORDER);
  localparam logic [RW-1:0] ROW_ONE  = RW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

  state_t state_q, state_d;

  // Input FIFO
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic          fifo_empty, fifo_full, push, pop;

  // Raster position of the next pixel to load
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          is_border, at_origin, at_eol, last_pos;

  // Output register and markers
  logic [7:0] pix_q, pix_d;
  logic       valid_q, valid_d;
  logic       sof_q, sof_d;
  logic       eol_q, eol_d;
  logic       eof_q, eof_d;
  logic       done_q, done_d;

  logic slot_free, load, eof_hs;

  assign fifo_empty = (level_q == '0);
  assign fifo_full  = (level_q == LVL_FULL);

  assign is_border = (row_q < ROW_LO) || (row_q >= ROW_HI) ||
                     (col_q < COL_LO) || (col_q >= COL_HI);
  assign at_origin = (row_q == '0) && (col_q == '0);
  assign at_eol    = (col_q == COL_LAST);
  assign last_pos  = at_eol && (row_q == ROW_LAST);

  assign slot_free = !valid_q || pixel_out_ready;
  assign pop       = load && !is_border;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept.
  assign push      = pixel_in_valid && (!fifo_full || pop);

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    if (!rstN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next-state logic
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // through the block leaves it unassigned and infers a latch.
    state_d = state_q;
    case (state_q)
      IDLE:    if (!fifo_empty)       state_d = STREAM;
      STREAM:  if (load && last_pos)  state_d = DRAIN;
      DRAIN:   if (eof_hs)            state_d = IDLE;
      default:                        state_d = IDLE;
    endcase
  end

  // FSM: output decode
  always_comb begin
    load   = 1'b0;
    eof_hs = 1'b0;
    case (state_q)
      STREAM:  load   = slot_free && (is_border || !fifo_empty);
      DRAIN:   eof_hs = valid_q && pixel_out_ready;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FIFO bookkeeping
  // ---------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q || (pixel_in_valid && !push);
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_ONE;
      2'b01:   level_d = level_q - LVL_ONE;
      default: ;
    endcase
  end

  // NOTE: the storage array has no reset; only pointers and level are cleared,
  // which keeps it mappable to plain RAM and stale words are never read.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= pixel_in;
  end

  // ---------------------------------------------------------------------------
  // Position counters and output register
  // ---------------------------------------------------------------------------
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    pix_d   = pix_q;
    valid_d = valid_q;
    sof_d   = sof_q;
    eol_d   = eol_q;
    eof_d   = eof_q;
    done_d  = eof_hs;
    if (load) begin
      valid_d = 1'b1;
      pix_d   = is_border ? PAD_VALUE : mem_q[rd_ptr_q];
      sof_d   = at_origin;
      eol_d   = at_eol;
      eof_d   = last_pos;
      if (at_eol) begin
        col_d = '0;
        row_d = last_pos ? '0 : row_q + ROW_ONE;
      end else begin
        col_d = col_q + COL_ONE;
      end
    end else if (pixel_out_ready) begin
      // Previous pixel taken and nothing available: bubble, counters hold.
      valid_d = 1'b0;
    end
    if (eof_hs) begin
      col_d = '0;
      row_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      col_q      <= '0;
      row_q      <= '0;
      pix_q      <= '0;
      valid_q    <= 1'b0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      eof_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      col_q      <= col_d;
      row_q      <= row_d;
      pix_q      <= pix_d;
      valid_q    <= valid_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      eof_q      <= eof_d;
      done_q     <= done_d;
    end
  end

  assign pixel_out       = pix_q;
  assign pixel_out_valid = valid_q;
  assign pixel_out_sof   = sof_q;
  assign pixel_out_eol   = eol_q;
  assign pixel_out_eof   = eof_q;
  assign frame_done      = done_q;
  assign overflow        = overflow_q;
  assign fifo_level      = level_q;

endmodule

// File: tb/tb_pixel_unloader.sv
// Scoreboard bench for pixel_unloader on a 6x5 raster: a deep-FIFO instance covers streaming,
// backpressure, reset and back-to-back frames; a 4-deep instance covers overflow and full+pop.
module tb_pixel_unloader;

  localparam int W    = 6;
  localparam int H    = 5;
  localparam int B    = 1;
  localparam int NPIX = (W - 2*B) * (H - 2*B);

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic [7:0] pin = '0;
  logic       vld = 1'b0;
  logic       ready = 1'b0;
  logic       sel = 1'b0;   // 0: 16-deep instance, 1: 4-deep instance
  logic       toggle = 1'b0;

  always #5 clk = ~clk;

  logic [7:0] a_pix, b_pix;
  logic       a_valid, a_sof, a_eol, a_eof, a_done, a_ovf;
  logic       b_valid, b_sof, b_eol, b_eof, b_done, b_ovf;
  logic [4:0] a_level;
  logic [2:0] b_level;

  pixel_unloader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(B), .FIFO_DEPTH(16), .PAD_VALUE(8'd0)) dut16 (
    .clk(clk), .rstN(rstN), .pixel_in(pin), .pixel_in_valid(vld & ~sel),
    .pixel_out(a_pix), .pixel_out_valid(a_valid), .pixel_out_ready(ready),
    .pixel_out_sof(a_sof), .pixel_out_eol(a_eol), .pixel_out_eof(a_eof),
    .frame_done(a_done), .overflow(a_ovf), .fifo_level(a_level)
  );

  pixel_unloader #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .BORDER(B), .FIFO_DEPTH(4), .PAD_VALUE(8'd0)) dut4 (
    .clk(clk), .rstN(rstN), .pixel_in(pin), .pixel_in_valid(vld & sel),
    .pixel_out(b_pix), .pixel_out_valid(b_valid), .pixel_out_ready(ready),
    .pixel_out_sof(b_sof), .pixel_out_eol(b_eol), .pixel_out_eof(b_eof),
    .frame_done(b_done), .overflow(b_ovf), .fifo_level(b_level)
  );

  logic [7:0]  m_pix;
  logic        m_valid, m_sof, m_eol, m_eof, m_done, m_ovf;
  logic [31:0] m_level;
  beat_t       m_beat;

  always_comb begin
    m_pix   = sel ? b_pix   : a_pix;
    m_valid = sel ? b_valid : a_valid;
    m_sof   = sel ? b_sof   : a_sof;
    m_eol   = sel ? b_eol   : a_eol;
    m_eof   = sel ? b_eof   : a_eof;
    m_done  = sel ? b_done  : a_done;
    m_ovf   = sel ? b_ovf   : a_ovf;
    m_level = sel ? 32'(b_level) : 32'(a_level);
    m_beat  = '{pix: m_pix, sof: m_sof, eol: m_eol, eof: m_eof};
  end

  int    n_vec = 0;
  int    n_bad = 0;
  int    hs_cnt = 0;
  int    done_cnt = 0;
  bit    pend_done = 0;
  bit    prev_stall = 0;
  beat_t held;
  beat_t sb[$];
  logic [7:0] fv [NPIX];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: samples on the falling edge what the next rising edge will see.
  always @(negedge clk) begin
    if (!rstN) begin
      prev_stall = 0;
      pend_done  = 0;
    end else begin
      if (pend_done) begin
        check("frame_done_pulse", 32'(m_done), 32'd1);
        pend_done = 0;
      end else if (m_done) begin
        check("frame_done_spurious", 32'(m_done), 32'd0);
      end
      if (m_done) done_cnt++;
      if (prev_stall) begin
        check("hold_valid", 32'(m_valid), 32'd1);
        check("hold_beat", 32'(m_beat), 32'(held));
      end
      if (m_valid && ready) begin
        hs_cnt++;
        if (sb.size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_output: got 0x%0h expected none", m_beat);
        end else begin
          beat_t e;
          e = sb.pop_front();
          check($sformatf("beat%0d", hs_cnt), 32'(m_beat), 32'(e));
        end
        if (m_eof) pend_done = 1;
      end
      prev_stall = m_valid && !ready;
      held       = m_beat;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (toggle) ready = ~ready;
  endtask

  task automatic do_reset();
    rstN = 1'b0;
    vld  = 1'b0;
    sb.delete();
    tick();
    rstN = 1'b1;
  endtask

  task automatic set_frame(input int first);
    for (int i = 0; i < NPIX; i++) fv[i] = 8'(first + i);
  endtask

  // Expected raster: interior positions consume fv[] in raster order, border is pad 0.
  task automatic exp_frame();
    int    k;
    bit    bd;
    beat_t e;
    k = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        bd = (r < B) || (r >= H - B) || (c < B) || (c >= W - B);
        e.pix = bd ? 8'd0 : fv[k];
        if (!bd) k++;
        e.sof = (r == 0) && (c == 0);
        e.eol = (c == W - 1);
        e.eof = (r == H - 1) && (c == W - 1);
        sb.push_back(e);
      end
    end
  endtask

  task automatic send(input int first, input int n, input int gap);
    for (int i = 0; i < n; i++) begin
      pin = 8'(first + i);
      vld = 1'b1;
      tick();
      vld = 1'b0;
      repeat (gap) tick();
    end
  endtask

  task automatic wait_empty(input string name, input int budget);
    int n;
    n = 0;
    while ((sb.size() != 0 || pend_done) && n < budget) begin
      tick();
      n++;
    end
    check({name, "_drained"}, 32'(sb.size()), 32'd0);
    repeat (3) tick();
  endtask

  task automatic check_idle(input string name);
    check({name, "_valid"}, 32'(m_valid), 32'd0);
    check({name, "_pix"},   32'(m_pix),   32'd0);
    check({name, "_marks"}, {29'd0, m_sof, m_eol, m_eof}, 32'd0);
    check({name, "_done"},  32'(m_done),  32'd0);
    check({name, "_ovf"},   32'(m_ovf),   32'd0);
    check({name, "_level"}, m_level,      32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    do_reset();
    check_idle("reset");

    // Basic frame with latency check: first push at edge N, valid at edge N+2.
    sel = 1'b0;
    ready = 1'b1;
    set_frame(1);
    exp_frame();
    pin = 8'd1; vld = 1'b1; tick();
    check("s1_lat_n", 32'(m_valid), 32'd0);
    pin = 8'd2; tick();
    check("s1_lat_n1", 32'(m_valid), 32'd0);
    pin = 8'd3; tick();
    check("s1_lat_n2", 32'(m_valid), 32'd1);
    check("s1_first_sof", 32'(m_sof), 32'd1);
    vld = 1'b0;
    send(4, 9, 0);
    wait_empty("s1", 200);
    check("s1_done_cnt", 32'(done_cnt), 32'd1);
    check("s1_ovf", 32'(m_ovf), 32'd0);

    // Backpressure: ready alternates 1,0,1,0.
    ready = 1'b1;
    toggle = 1'b1;
    set_frame(1);
    exp_frame();
    send(1, NPIX, 0);
    wait_empty("s2", 400);
    toggle = 1'b0;
    ready = 1'b1;
    check("s2_done_cnt", 32'(done_cnt), 32'd2);
    check("s2_ovf", 32'(m_ovf), 32'd0);

    // Overflow on the 4-deep instance: 5 and 6 are dropped.
    sel = 1'b1;
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) fv[i] = 8'(i + 1);
    for (int i = 4; i < NPIX; i++) fv[i] = 8'(i + 3);
    exp_frame();
    send(1, 6, 0);
    check("s3_level", m_level, 32'd4);
    check("s3_ovf", 32'(m_ovf), 32'd1);
    ready = 1'b1;
    repeat (10) tick();
    check("s3_ovf_sticky", 32'(m_ovf), 32'd1);
    send(7, 8, 1);
    wait_empty("s3", 300);
    check("s3_ovf_end", 32'(m_ovf), 32'd1);
    check("s3_done_cnt", 32'(done_cnt), 32'd3);

    // Full FIFO with a simultaneous interior pop: push of 7 accepted.
    do_reset();
    ready = 1'b0;
    for (int i = 0; i < 4; i++) fv[i] = 8'(i + 1);
    for (int i = 4; i < NPIX; i++) fv[i] = 8'(i + 3);
    exp_frame();
    send(1, 4, 0);
    check("s4_level_full", m_level, 32'd4);
    ready = 1'b1;
    repeat (6) tick();
    check("s4_level_pre", m_level, 32'd4);
    send(7, 1, 0);
    check("s4_level_post", m_level, 32'd4);
    check("s4_ovf", 32'(m_ovf), 32'd0);
    send(8, 7, 1);
    wait_empty("s4", 300);
    check("s4_ovf_end", 32'(m_ovf), 32'd0);
    check("s4_done_cnt", 32'(done_cnt), 32'd4);

    // Reset after 10 output handshakes, then a fresh frame.
    sel = 1'b0;
    do_reset();
    check_idle("s5_pre");
    ready = 1'b1;
    set_frame(1);
    exp_frame();
    base = hs_cnt;
    send(1, NPIX, 0);
    for (int n = 0; n < 100 && hs_cnt < base + 10; n++) tick();
    check("s5_hs_before_reset", 32'(hs_cnt - base), 32'd10);
    do_reset();
    check_idle("s5_post");
    set_frame(21);
    exp_frame();
    send(21, NPIX, 0);
    wait_empty("s5", 200);
    check("s5_done_cnt", 32'(done_cnt), 32'd5);

    // Back-to-back frames from one continuous burst of 24 pixels.
    set_frame(41);
    exp_frame();
    set_frame(53);
    exp_frame();
    send(41, 2 * NPIX, 0);
    wait_empty("s6", 600);
    check("s6_done_cnt", 32'(done_cnt), 32'd7);
    check("s6_ovf", 32'(m_ovf), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
